mac_vector_driver: RTL and testbench

Sequencer that sits upstream of the 12-bit signed multiply-accumulate unit and turns a buffered pair of operand vectors into a complete dot product. Software loads up to DEPTH (a, b) pairs, then pulses start. The block clears the MAC, streams the pairs on the MAC's valid_in interface, and counts the MAC's valid_out responses. It returns the final 24-bit accumulator value with a one-cycle result_valid pulse.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_operand_buf.sv | 27 ++
 rtl/mac_vector_driver.sv | 132 +++++++++++++
 tb/tb_mac_vector_driver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC vector driver and its operand buffer.
package mac_pkg;

    localparam int A_W = 12;
    localparam int F_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } drv_state_t;

    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [A_W-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mac_operand_buf.sv
// Operand-pair register file: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after we; read is same-cycle. No backpressure; storage is not reset.
module mac_operand_buf
    import mac_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  operand_pair_t wdata,
    input  logic [AW-1:0] raddr,
    output operand_pair_t rdata
);

    operand_pair_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mac_vector_driver.sv
// Streams buffered operand pairs through the MAC and returns the final accumulator as a dot product.
// Latency: result_valid N+4 cycles after start for N pairs (2 cycles for an empty buffer).
// Backpressure: load_ready drops when the buffer is full or while a computation is in flight.
module mac_vector_driver
    import mac_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic signed [A_W-1:0] load_a,
    input  logic signed [A_W-1:0] load_b,
    output logic                  load_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  mac_clear,
    output logic signed [A_W-1:0] mac_a,
    output logic signed [A_W-1:0] mac_b,
    output logic                  mac_valid_in,
    input  logic signed [F_W-1:0] mac_f,
    input  logic                  mac_valid_out,
    output logic signed [F_W-1:0] result,
    output logic                  result_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    drv_state_t    state;
    drv_state_t    state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] rd_idx;
    logic [CW-1:0] resp_cnt;
    logic          load_fire;
    logic          last_rd;
    logic          resp_fire;
    logic          resp_last;
    operand_pair_t wr_pair;
    operand_pair_t rd_pair;

    assign load_ready = (state == IDLE) && (count < FULL);
    assign load_fire  = load_valid && load_ready;
    assign last_rd    = (rd_idx == count - ONE);
    assign resp_fire  = mac_valid_out && ((state == STREAM) || (state == DRAIN));
    assign resp_last  = resp_fire && ((resp_cnt + ONE) == count);

    assign wr_pair.a = load_a;
    assign wr_pair.b = load_b;

    mac_operand_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (load_fire),
        .waddr (count[AW-1:0]),
        .wdata (wr_pair),
        .raddr (rd_idx[AW-1:0]),
        .rdata (rd_pair)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An empty buffer still passes through CLEAR so its result lands two cycles after start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (count == '0) ? DONE : STREAM;
            STREAM: begin
                if (resp_last) begin
                    state_nxt = DONE;
                end else if (last_rd) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   if (resp_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rd_idx   <= '0;
            resp_cnt <= '0;
            result   <= '0;
        end else begin
            if (state == DONE) begin
                count <= '0;
            end else if (load_fire) begin
                count <= count + ONE;
            end

            if (state == CLEAR) begin
                rd_idx   <= '0;
                resp_cnt <= '0;
                if (count == '0) begin
                    result <= '0;
                end
            end

            if (state == STREAM) begin
                rd_idx <= rd_idx + ONE;
            end

            if (resp_fire) begin
                resp_cnt <= resp_cnt + ONE;
            end
            if (resp_last) begin
                result <= mac_f;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign mac_clear    = (state == CLEAR);
    assign mac_valid_in = (state == STREAM);
    assign mac_a        = (state == STREAM) ? rd_pair.a : '0;
    assign mac_b        = (state == STREAM) ? rd_pair.b : '0;
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_mac_vector_driver.sv
// Randomized scoreboard bench for mac_vector_driver with a behavioural two-stage MAC alongside.
module tb_mac_vector_driver;
    import mac_pkg::*;

    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  load_valid = 1'b0;
    logic signed [A_W-1:0] load_a = '0;
    logic signed [A_W-1:0] load_b = '0;
    logic                  load_ready;
    logic                  start = 1'b0;
    logic                  busy;
    logic                  mac_clear;
    logic signed [A_W-1:0] mac_a;
    logic signed [A_W-1:0] mac_b;
    logic                  mac_valid_in;
    logic signed [F_W-1:0] mac_f = '0;
    logic                  mac_valid_out = 1'b0;
    logic signed [F_W-1:0] result;
    logic                  result_valid;

    mac_vector_driver #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_a        (load_a),
        .load_b        (load_b),
        .load_ready    (load_ready),
        .start         (start),
        .busy          (busy),
        .mac_clear     (mac_clear),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .result        (result),
        .result_valid  (result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream MAC: registers valid_in, then accumulates one cycle later.
    logic                  v1 = 1'b0;
    logic signed [A_W-1:0] a1 = '0;
    logic signed [A_W-1:0] b1 = '0;
    logic signed [F_W-1:0] prod;
    assign prod = F_W'(a1) * F_W'(b1);

    always @(posedge clk) begin
        if (reset || mac_clear) begin
            v1            <= 1'b0;
            mac_valid_out <= 1'b0;
            mac_f         <= '0;
        end else begin
            v1            <= mac_valid_in;
            a1            <= mac_a;
            b1            <= mac_b;
            mac_valid_out <= v1;
            if (v1) mac_f <= mac_f + prod;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: the pairs software believes are buffered, and the dot products owed.
    int qa[$];
    int qb[$];

    typedef struct {
        logic [F_W-1:0] res;
        int             cyc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [F_W-1:0] model_dot();
        int s = 0;
        foreach (qa[i]) s += qa[i] * qb[i];
        return s[F_W-1:0];
    endfunction

    always @(negedge clk) begin
        if (!reset && result_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_result_valid: got result_valid=1 result=0x%0h at cycle %0d, required no pulse",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {8'h0, result}, {8'h0, e.res});
                chk("result_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a rising edge; presents one pair for one cycle.
    task automatic do_load(input int a, input int b);
        bit exp_rdy;
        load_valid = 1'b1;
        load_a     = A_W'(a);
        load_b     = A_W'(b);
        @(negedge clk);
        exp_rdy = (qa.size() < DEPTH);
        chk("load_ready", load_ready, exp_rdy);
        @(posedge clk);
        if (exp_rdy) begin
            qa.push_back(a);
            qb.push_back(b);
        end
        #1;
        load_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_load, input int a, input int b, input bit expect_result,
                            output int n);
        int c0;
        exp_t e;
        start = 1'b1;
        if (with_load) begin
            load_valid = 1'b1;
            load_a     = A_W'(a);
            load_b     = A_W'(b);
        end
        c0 = cyc;
        @(posedge clk);
        if (with_load && qa.size() < DEPTH) begin
            qa.push_back(a);
            qb.push_back(b);
        end
        n = qa.size();
        if (expect_result) begin
            e.res = model_dot();
            e.cyc = c0 + ((n == 0) ? 2 : n + 4);
            sb.push_back(e);
        end
        qa.delete();
        qb.delete();
        #1;
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input bit poke);
        int clr = 0;
        int vin = 0;
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            clr += int'(mac_clear);
            vin += int'(mac_valid_in);
            chk("load_ready_while_busy", load_ready, 0);
            if (poke) begin
                start      = 1'($urandom_range(0, 1));
                load_valid = 1'b1;
                load_a     = A_W'($urandom);
                load_b     = A_W'($urandom);
            end
        end
        start      = 1'b0;
        load_valid = 1'b0;
        chk("returned_to_idle", done, 1);
        chk("mac_clear_pulses", clr, 1);
        chk("mac_valid_in_cycles", vin, n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mac_clear", mac_clear, 0);
        chk("rst_mac_a", {20'h0, mac_a}, 0);
        chk("rst_mac_b", {20'h0, mac_b}, 0);
        chk("rst_mac_valid_in", mac_valid_in, 0);
        chk("rst_result", {8'h0, result}, 0);
        chk("rst_result_valid", result_valid, 0);
        @(posedge clk);
        #1;

        // Three-pair vector: 12 - 30 - 56 = -74.
        do_load(3, 4);
        do_load(-5, 6);
        do_load(7, -8);
        do_start(1'b0, 0, 0, 1'b1, n);
        wait_done(n, 1'b0);

        // Empty buffer.
        do_start(1'b0, 0, 0, 1'b1, n);
        wait_done(n, 1'b0);

        // Full buffer of max positive pairs plus a rejected ninth load; wraps to 0xFF8008.
        for (int i = 0; i < DEPTH + 1; i++) do_load(2047, 2047);
        do_start(1'b0, 0, 0, 1'b1, n);
        wait_done(n, 1'b0);

        // Back-to-back: 2, then -3, with interference while busy on the second.
        do_load(1, 1);
        do_load(1, 1);
        do_start(1'b0, 0, 0, 1'b1, n);
        wait_done(n, 1'b0);
        for (int i = 0; i < 3; i++) do_load(-1, 1);
        do_start(1'b0, 0, 0, 1'b1, n);
        wait_done(n, 1'b1);

        // Reset in the middle of STREAM: no result, buffer emptied.
        for (int i = 0; i < 5; i++) do_load(i + 1, 3);
        do_start(1'b0, 0, 0, 1'b0, n);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_load_ready", load_ready, 1);
        chk("abort_mac_valid_in", mac_valid_in, 0);
        repeat (12) @(posedge clk);
        #1;
        do_load(10, 10);
        do_start(1'b0, 0, 0, 1'b1, n);
        wait_done(n, 1'b0);

        // Load coinciding with start is part of the vector.
        do_load(-2048, -2048);
        do_start(1'b1, 5, -7, 1'b1, n);
        wait_done(n, 1'b0);

        // Randomized vectors.
        for (int t = 0; t < 30; t++) begin
            int nl;
            nl = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < nl; i++) begin
                logic signed [A_W-1:0] ra;
                logic signed [A_W-1:0] rb;
                ra = A_W'($urandom);
                rb = A_W'($urandom);
                do_load(int'(ra), int'(rb));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            begin
                logic signed [A_W-1:0] sa;
                logic signed [A_W-1:0] sbv;
                sa  = A_W'($urandom);
                sbv = A_W'($urandom);
                do_start(($urandom_range(0, 3) == 0), int'(sa), int'(sbv), 1'b1, n);
            end
            wait_done(n, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL outstanding_results: got %0d results never delivered, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
